// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: default sizes and FSM state encoding.
package int_ctrl_pkg;

    localparam int unsigned N_SRC_DEF = 4;
    localparam int unsigned VEC_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_SERV = 2'b10
    } state_t;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit plus a valid flag.
module int_ctrl_prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_valid_c
);

    // Scan from the top down so the lowest index overwrites last and wins.
    always_comb begin
        o_idx_c   = '0;
        o_valid_c = |i_req;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises request lines, latches edges as pending, masks,
// arbitrates by fixed priority and runs the request/ack/done handshake with the control unit.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEF,
    parameter int unsigned VEC_W = VEC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_din,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             interrupcion,
    output logic [VEC_W-1:0] vector,
    output logic [N_SRC-1:0] pending,
    output logic             in_service
);

    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic [IDX_W-1:0] r_cur;
    logic [VEC_W-1:0] r_vector;
    logic             r_irq;
    logic             r_in_serv;
    state_t           r_state;

    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_req;
    logic [N_SRC-1:0] w_clr;
    logic [IDX_W-1:0] w_win;
    logic             w_win_valid;
    state_t           w_nxt_state;
    logic [IDX_W-1:0] w_nxt_cur;
    logic [VEC_W-1:0] w_nxt_vector;

    assign w_edge = r_sync2 & ~r_prev;
    assign w_req  = r_pending & r_mask;

    int_ctrl_prio_enc #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_req     (w_req),
        .o_idx_c   (w_win),
        .o_valid_c (w_win_valid)
    );

    // Two-flop synchroniser followed by the previous-value register for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // A fresh edge on a bit being acknowledged re-sets it, so the new event is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (mask_we) begin
                r_mask <= mask_din;
            end
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cur    = r_cur;
        w_nxt_vector = r_vector;
        w_clr        = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_nxt_cur    = w_win;
                    w_nxt_vector = VEC_W'(w_win);
                    w_nxt_state  = ST_REQ;
                end
            end
            ST_REQ: begin
                // No re-arbitration here: the accepted source stays until ack or withdrawal.
                if (int_ack) begin
                    w_clr[r_cur] = 1'b1;
                    w_nxt_state  = ST_SERV;
                end else if (!r_mask[r_cur]) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_SERV: begin
                if (int_done) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Request is raised one cycle after entering REQ and drops on the edge that leaves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cur     <= '0;
            r_vector  <= '0;
            r_irq     <= 1'b0;
            r_in_serv <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cur     <= w_nxt_cur;
            r_vector  <= w_nxt_vector;
            r_irq     <= (r_state == ST_REQ) && (w_nxt_state == ST_REQ);
            r_in_serv <= (w_nxt_state == ST_SERV);
        end
    end

    assign interrupcion = r_irq;
    assign vector       = r_vector;
    assign pending      = r_pending;
    assign in_service   = r_in_serv;

endmodule
